// File: rtl/ring_shift_receiver.sv
// ring_shift_receiver: serial-in/parallel-out receiver for the 6-bit ring shift link.
// Bits arrive LSB first, one per sin_valid strobe, and a frame opens with start on bit 0.
// Completed words are loaded into a holding register that has a valid/ready handshake.
// A word that completes while that register is full and not being read is dropped,
// and the sticky overrun flag is set.
// Optional feature: define RSR_PARITY_EN to add a trailing even-parity bit. That bit is
// checked, and its result is reported on parity_err alongside q_out.
module ring_shift_receiver #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  input  logic             q_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_out_q, q_out_d;
  logic               q_valid_q, q_valid_d;
  logic               overrun_q, overrun_d;
  logic               done;
  logic [WIDTH-1:0]   word;
`ifdef RSR_PARITY_EN
  logic               perr_q, perr_d;
  logic               perr_new;
`endif

  // Framing FSM, shift/count datapath and holding-register delivery
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    q_out_d   = q_out_q;
    // A transfer empties the holding register unless a new word lands below
    q_valid_d = q_valid_q & ~q_ready;
    // A same-cycle overrun below overrides clr_ovr
    overrun_d = overrun_q & ~clr_ovr;
    done      = 1'b0;
    word      = {sin, sr_q[WIDTH-1:1]};
`ifdef RSR_PARITY_EN
    perr_d    = perr_q;
    perr_new  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (sin_valid && start) begin
          sr_d    = {sin, {(WIDTH-1){1'b0}}};
          cnt_d   = CNT_W'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (sin_valid) begin
          if (start) begin
            // Resync: drop the partial word, this bit becomes bit 0
            sr_d  = {sin, {(WIDTH-1){1'b0}}};
            cnt_d = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WIDTH-1)) begin
            sr_d  = word;
            cnt_d = '0;
`ifdef RSR_PARITY_EN
            state_d = StParity;
`else
            done    = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            sr_d  = word;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef RSR_PARITY_EN
      StParity: begin
        if (sin_valid) begin
          if (start) begin
            sr_d    = {sin, {(WIDTH-1){1'b0}}};
            cnt_d   = CNT_W'(1);
            state_d = StShift;
          end else begin
            // Full word already sits in sr; sin is the even-parity bit
            word     = sr_q;
            perr_new = sin ^ (^sr_q);
            done     = 1'b1;
            state_d  = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (done) begin
      if (!q_valid_q || q_ready) begin
        q_out_d   = word;
        q_valid_d = 1'b1;
`ifdef RSR_PARITY_EN
        perr_d    = perr_new;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      q_out_q   <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef RSR_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      q_out_q   <= q_out_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
`ifdef RSR_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign q_out   = q_out_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q != StIdle);
  assign overrun = overrun_q;
`ifdef RSR_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
